// File: rtl/mdr_controller_if.sv
// Bus-side signal bundle for the memory data register controller.
// The slave modport is the controller's view; master is the driving side.
interface mdr_controller_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] BusMuxOut;
    logic              MDR_enable;
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [1:0]        size;
    logic              sign_ext;
    logic [1:0]        addr_lo;
    logic [DATA_W-1:0] MDataIn;
    logic              mem_ready;
    logic [DATA_W-1:0] Q;
    logic [DATA_W-1:0] MDataOut;
    logic              mem_rd;
    logic              mem_wr;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  BusMuxOut, MDR_enable, mem_rd_req, mem_wr_req, size, sign_ext,
               addr_lo, MDataIn, mem_ready,
        output Q, MDataOut, mem_rd, mem_wr, busy, done, err
    );

    modport master (
        output BusMuxOut, MDR_enable, mem_rd_req, mem_wr_req, size, sign_ext,
               addr_lo, MDataIn, mem_ready,
        input  Q, MDataOut, mem_rd, mem_wr, busy, done, err
    );
endinterface

// File: rtl/mdr_controller.sv
// Memory data register with a read/write handshake FSM, sub-word read
// extraction and a mem_ready timeout.
module mdr_controller #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             clr,
    mdr_controller_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic              sx_q, sx_d;
    logic [1:0]        lane_q, lane_d;

    function automatic logic [DATA_W-1:0] extract(
        input logic [DATA_W-1:0] din,
        input logic [1:0]        sz,
        input logic              sx,
        input logic [1:0]        lane
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = 8'(din[31:0] >> {lane, 3'b000});
        h = 16'(din[31:0] >> {lane[1], 4'b0000});
        case (sz)
            2'b00:   r = {{(DATA_W-8){sx & b[7]}}, b};
            2'b01:   r = {{(DATA_W-16){sx & h[15]}}, h};
            default: r = din;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            sx_q    <= 1'b0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            sx_q    <= sx_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        sx_d    = sx_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_rd_req) begin
                    state_d = READ;
                    cnt_d   = '0;
                    size_d  = bus.size;
                    sx_d    = bus.sign_ext;
                    lane_d  = bus.addr_lo;
                end else if (bus.mem_wr_req) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end else if (bus.MDR_enable) begin
                    q_d = bus.BusMuxOut;
                end
            end
            READ: begin
                // mem_ready wins over an expiring counter in the same cycle
                if (bus.mem_ready) begin
                    q_d     = extract(bus.MDataIn, size_q, sx_q, lane_q);
                    state_d = DONE;
                end else if (cnt_q == TMO) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WRITE: begin
                if (bus.mem_ready) begin
                    state_d = DONE;
                end else if (cnt_q == TMO) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.Q        = q_q;
    assign bus.MDataOut = q_q;
    assign bus.mem_rd   = (state_q == READ);
    assign bus.mem_wr   = (state_q == WRITE);
    assign bus.busy     = (state_q == READ) || (state_q == WRITE);
    assign bus.done     = (state_q == DONE);
    assign bus.err      = (state_q == ERR);
endmodule

// File: tb/tb_mdr_controller.sv
// Directed bench for mdr_controller: stimulus pushes expected completions into
// a scoreboard queue, a negedge monitor pops them on every done/err pulse.
module tb_mdr_controller;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic        is_err;
        logic [31:0] q;
    } exp_t;

    typedef struct packed {
        logic [1:0]  sz;
        logic        sx;
        logic [1:0]  lane;
        logic [31:0] din;
        logic [31:0] exp;
    } rd_vec_t;

    logic clk;
    logic clr;
    int   errors;
    int   checks;
    exp_t sb[$];

    mdr_controller_if #(.DATA_W(DATA_W)) bus();

    mdr_controller #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!clr && (bus.done === 1'b1 || bus.err === 1'b1)) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got done=%b err=%b expected none",
                         bus.done, bus.err);
            end else begin
                e = sb.pop_front();
                chk("completion_kind", {31'd0, bus.err}, {31'd0, e.is_err});
                chk("completion_q", bus.Q, e.q);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic load(input logic [31:0] v);
        @(negedge clk);
        bus.MDR_enable = 1'b1;
        bus.BusMuxOut  = v;
        @(negedge clk);
        bus.MDR_enable = 1'b0;
        chk("load_q", bus.Q, v);
        chk("load_strobes", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
    endtask

    task automatic do_read(input rd_vec_t v, input int waits);
        @(negedge clk);
        bus.mem_rd_req = 1'b1;
        bus.size       = v.sz;
        bus.sign_ext   = v.sx;
        bus.addr_lo    = v.lane;
        bus.MDataIn    = v.din;
        bus.mem_ready  = 1'b0;
        sb.push_back('{is_err: 1'b0, q: v.exp});
        @(negedge clk);
        bus.mem_rd_req = 1'b0;
        bus.size       = ~v.sz;
        bus.sign_ext   = ~v.sx;
        bus.addr_lo    = ~v.lane;
        bus.MDR_enable = 1'b1;
        bus.BusMuxOut  = 32'h0BAD0BAD;
        chk("read_strobe", {30'd0, bus.mem_rd, bus.busy}, 32'd3);
        for (int i = 0; i < waits; i++) @(negedge clk);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready  = 1'b0;
        bus.MDR_enable = 1'b0;
        @(negedge clk);
        chk("read_idle_after", {29'd0, bus.done, bus.busy, bus.err}, 32'd0);
    endtask

    rd_vec_t rd_tab[6];
    logic [31:0] qsave;
    int  wr_cycles;
    bit  seen_err;

    initial begin
        errors = 0;
        checks = 0;
        clr = 1'b1;
        bus.BusMuxOut  = '0;
        bus.MDR_enable = 1'b0;
        bus.mem_rd_req = 1'b0;
        bus.mem_wr_req = 1'b0;
        bus.size       = '0;
        bus.sign_ext   = 1'b0;
        bus.addr_lo    = '0;
        bus.MDataIn    = '0;
        bus.mem_ready  = 1'b0;

        rd_tab[0] = '{sz: 2'b01, sx: 1'b0, lane: 2'd3, din: 32'h9ABC1234, exp: 32'h00009ABC};
        rd_tab[1] = '{sz: 2'b01, sx: 1'b1, lane: 2'd1, din: 32'h00008001, exp: 32'hFFFF8001};
        rd_tab[2] = '{sz: 2'b10, sx: 1'b1, lane: 2'd0, din: 32'hCAFEF00D, exp: 32'hCAFEF00D};
        rd_tab[3] = '{sz: 2'b00, sx: 1'b0, lane: 2'd3, din: 32'hA5000000, exp: 32'h000000A5};
        rd_tab[4] = '{sz: 2'b00, sx: 1'b1, lane: 2'd0, din: 32'h0000007F, exp: 32'h0000007F};
        rd_tab[5] = '{sz: 2'b11, sx: 1'b0, lane: 2'd2, din: 32'h12345678, exp: 32'h12345678};

        #1;
        chk("reset_q", bus.Q, 32'd0);
        chk("reset_status", {27'd0, bus.mem_rd, bus.mem_wr, bus.busy, bus.done, bus.err}, 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b0;

        load(32'hDEADBEEF);

        // Byte read, sign-extended, two wait cycles, inputs scrambled after accept
        do_read('{sz: 2'b00, sx: 1'b1, lane: 2'd2, din: 32'h1280FF00, exp: 32'hFFFFFF80}, 2);
        foreach (rd_tab[i]) do_read(rd_tab[i], 0);

        // Write that never completes: timeout to ERR, Q untouched
        load(32'h55AA55AA);
        @(negedge clk);
        bus.mem_wr_req = 1'b1;
        sb.push_back('{is_err: 1'b1, q: 32'h55AA55AA});
        wr_cycles = 0;
        seen_err  = 1'b0;
        for (int i = 0; i < 100 && !seen_err; i++) begin
            @(negedge clk);
            bus.mem_wr_req = 1'b0;
            bus.mem_rd_req = (i == 2);
            if (bus.mem_wr === 1'b1) begin
                wr_cycles++;
                if (wr_cycles == 1) chk("write_mdataout", bus.MDataOut, 32'h55AA55AA);
            end
            if (bus.err === 1'b1) seen_err = 1'b1;
        end
        bus.mem_rd_req = 1'b0;
        chk("timeout_seen", {31'd0, seen_err}, 32'd1);
        chk("mem_wr_cycles", wr_cycles, TIMEOUT + 1);
        @(negedge clk);
        chk("idle_after_err", {29'd0, bus.err, bus.busy, bus.mem_rd}, 32'd0);

        // mem_ready arriving exactly when the counter hits TIMEOUT completes
        @(negedge clk);
        bus.mem_wr_req = 1'b1;
        sb.push_back('{is_err: 1'b0, q: 32'h55AA55AA});
        @(negedge clk);
        bus.mem_wr_req = 1'b0;
        repeat (TIMEOUT) @(negedge clk);
        chk("write_still_busy", {31'd0, bus.mem_wr}, 32'd1);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        chk("boundary_done", {30'd0, bus.done, bus.err}, 32'd2);
        @(negedge clk);

        // Simultaneous read/write requests with MDR_enable: read wins, no load
        qsave = bus.Q;
        bus.mem_rd_req = 1'b1;
        bus.mem_wr_req = 1'b1;
        bus.MDR_enable = 1'b1;
        bus.BusMuxOut  = 32'h11111111;
        bus.size       = 2'b10;
        bus.MDataIn    = 32'h76543210;
        sb.push_back('{is_err: 1'b0, q: 32'h76543210});
        @(negedge clk);
        bus.mem_rd_req = 1'b0;
        bus.mem_wr_req = 1'b0;
        bus.MDR_enable = 1'b0;
        chk("priority_strobes", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd2);
        chk("priority_no_load", bus.Q, qsave);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);

        // Asynchronous clear during READ with mem_ready pending
        bus.mem_rd_req = 1'b1;
        bus.size       = 2'b10;
        bus.MDataIn    = 32'hFEEDFACE;
        @(negedge clk);
        bus.mem_rd_req = 1'b0;
        bus.mem_ready  = 1'b1;
        #2;
        clr = 1'b1;
        #1;
        chk("clr_q", bus.Q, 32'd0);
        chk("clr_strobes", {27'd0, bus.mem_rd, bus.mem_wr, bus.busy, bus.done, bus.err}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        bus.mem_ready = 1'b0;
        load(32'hA1B2C3D4);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mdr_controller.md
MDR_CONTROLLER -- requirements
Module: mdr_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data path width; legal values are multiples of 32.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum wait cycles for mem_ready before error; legal range 1-255.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; ports named clk and clr.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 clr  input  1  asynchronous active-high reset.
REQ-006 BusMuxOut  input  DATA_W  data from internal bus.
REQ-007 MDR_enable  input  1  load Q from BusMuxOut.
REQ-008 mem_rd_req  input  1  start memory read transaction.
REQ-009 mem_wr_req  input  1  start memory write transaction.
REQ-010 size  input  2  read size: 00 byte, 01 halfword, 1x word.
REQ-011 sign_ext  input  1  1 = sign-extend sub-word reads, 0 = zero-extend.
REQ-012 addr_lo  input  2  low address bits selecting byte/halfword lane.
REQ-013 MDataIn  input  DATA_W  data from memory.
REQ-014 mem_ready  input  1  memory completes the current transaction this cycle.
REQ-015 Q  output  DATA_W  register contents, to bus.
REQ-016 MDataOut  output  DATA_W  write data to memory; always equals Q.
REQ-017 mem_rd, mem_wr  output  1 each  memory strobes.
REQ-018 busy, done, err  output  1 each  status.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, DONE, ERR.
REQ-020 In IDLE, mem_rd_req SHALL move to READ next edge; otherwise mem_wr_req SHALL move to WRITE (read has priority).
REQ-021 In IDLE with no request, MDR_enable=1 SHALL load Q<=BusMuxOut at the edge; MDR_enable SHALL be ignored in a cycle carrying a request and in all non-IDLE states.
REQ-022 size, sign_ext, addr_lo SHALL be latched at read acceptance and held for the transaction.
REQ-023 Requests arriving outside IDLE SHALL be ignored (not queued).
REQ-024 READ: mem_rd=1, busy=1; on a cycle with mem_ready=1, Q SHALL load the extracted MDataIn and FSM SHALL go to DONE.
REQ-025 Extraction on the low 32 bits: byte = bits[8*addr_lo+7 : 8*addr_lo]; halfword = bits[16*addr_lo[1]+15 : 16*addr_lo[1]], addr_lo[0] ignored; word = all DATA_W bits unmodified. Sub-word results SHALL be extended to DATA_W per sign_ext.
REQ-026 WRITE: mem_wr=1, busy=1, MDataOut=Q; mem_ready=1 SHALL move to DONE; Q unchanged.
REQ-027 A wait counter SHALL clear on entering READ/WRITE and increment each cycle mem_ready=0; if it reaches TIMEOUT without mem_ready, FSM SHALL go to ERR, Q unchanged.
REQ-028 mem_ready=1 in the cycle the counter reaches TIMEOUT SHALL count as completion (DONE, not ERR).
REQ-029 DONE: done=1 for exactly one cycle, then IDLE; ERR: err=1 for exactly one cycle, then IDLE.
REQ-030 mem_ready outside READ/WRITE SHALL be ignored.
REQ-031 Minimum transaction latency: request cycle, one READ/WRITE cycle with mem_ready, one DONE cycle = IDLE again 3 edges after request.
REQ-032 All outputs SHALL be registered or decoded from state only; no combinational path from inputs to outputs except MDataOut=Q.

Reset
REQ-033 clr=1 SHALL immediately force state IDLE, Q=0, wait counter=0, mem_rd=mem_wr=busy=done=err=0, regardless of clk.
REQ-034 clr asserted mid-transaction SHALL abort it with no Q update; first edge after release SHALL behave as IDLE.

Verification
REQ-035 IDLE, MDR_enable=1, BusMuxOut=0xDEADBEEF -> Q=0xDEADBEEF next edge, mem_rd=mem_wr=0.
REQ-036 mem_rd_req, size=00, addr_lo=2, sign_ext=1, MDataIn=0x1280FF00, mem_ready after 2 waits -> Q=0xFFFFFF80, done pulse 1 cycle.
REQ-037 mem_rd_req, size=01, addr_lo=3, sign_ext=0, MDataIn=0x9ABC1234, mem_ready immediate -> Q=0x00009ABC.
REQ-038 Q=0x55AA55AA, mem_wr_req, mem_ready never -> mem_wr high TIMEOUT+1 cycles, err pulse 1 cycle, Q=0x55AA55AA.
REQ-039 mem_rd_req and mem_wr_req same cycle with MDR_enable=1 -> READ entered, Q not loaded from BusMuxOut.
REQ-040 clr pulse during READ with mem_ready=1 pending -> Q=0, all strobes 0 immediately, state IDLE.
